// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the in-order MEM/WB result and a FIFO of long-latency results
// onto the single regfile write port, tracks pending destinations, and requests bubbles on starvation.
module wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        pipe_wen_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,

  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_waddr_i,
  input  logic [31:0] lu_wdata_i,

  input  logic        issue_i,
  input  logic [4:0]  issue_addr_i,

  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        rd_busy_o,

  output logic        stall_o,

  output logic        wen_o,
  output logic [4:0]  wr_addr_o,
  output logic [31:0] wr_data_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned AgeW = $clog2(STARVE_MAX + 1);

  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [AgeW-1:0] AgeMax  = AgeW'(STARVE_MAX);

  // Result storage; data-only, so no reset is needed.
  logic [4:0]      mem_addr_q [DEPTH];
  logic [31:0]     mem_data_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:1]     busy_q, busy_d;
  logic [AgeW-1:0] age_q, age_d;
  logic            stall_q, stall_d;

  logic            fifo_full;
  logic            fifo_empty;
  logic            pipe_sel;
  logic            push;
  logic            pop;
  logic [4:0]      head_addr;
  logic [31:0]     head_data;
  logic [31:0]     busy_view;
  logic [31:0]     busy_nxt;

  assign fifo_full  = (count_q == CntFull);
  assign fifo_empty = (count_q == '0);
  assign head_addr  = mem_addr_q[rd_ptr_q];
  assign head_data  = mem_data_q[rd_ptr_q];

  // A pipe write to x0 is treated as idle so the FIFO can drain underneath it.
  assign pipe_sel   = pipe_wen_i && (pipe_waddr_i != 5'd0);
  assign lu_ready_o = rstn && !fifo_full;
  assign push       = lu_valid_i && lu_ready_o;
  assign pop        = !pipe_sel && !fifo_empty;

  always_comb begin
    wen_o     = 1'b0;
    wr_addr_o = 5'd0;
    wr_data_o = 32'd0;
    if (rstn) begin
      if (pipe_sel) begin
        wen_o     = 1'b1;
        wr_addr_o = pipe_waddr_i;
        wr_data_o = pipe_wdata_i;
      end else if (pop && (head_addr != 5'd0)) begin
        wen_o     = 1'b1;
        wr_addr_o = head_addr;
        wr_data_o = head_data;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Bit 0 is a scratch slot so x0 sets/clears fall away without extra compares.
  always_comb begin
    busy_nxt = {busy_q, 1'b0};
    if (pop) begin
      busy_nxt[head_addr] = 1'b0;
    end
    if (issue_i) begin
      busy_nxt[issue_addr_i] = 1'b1;
    end
    busy_d = busy_nxt[31:1];
  end

  assign busy_view  = {busy_q, 1'b0};
  assign rs1_busy_o = busy_view[rs1_addr_i];
  assign rs2_busy_o = busy_view[rs2_addr_i];
  assign rd_busy_o  = busy_view[rd_addr_i];

  // Age only advances while the head is blocked by a pipe write.
  always_comb begin
    age_d = age_q;
    if (pop || fifo_empty) begin
      age_d = '0;
    end else if (age_q != AgeMax) begin
      age_d = age_q + AgeW'(1);
    end
    stall_d = (age_d == AgeMax);
  end

  assign stall_o = stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      age_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      age_q    <= age_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= lu_waddr_i;
      mem_data_q[wr_ptr_q] <= lu_wdata_i;
    end
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage arbiter. It sits directly upstream of the register file write port (wen / wr_addr_i / wr_data_i).
- It merges two result sources into that single write port:
  - the in-order MEM/WB pipeline result;
  - results from long-latency units (divider, for example).
- Long-latency results are held in a small FIFO. A scoreboard of pending destination registers lets ID stall on RAW/WAW hazards.
- A starvation counter requests a pipeline bubble so buffered results always retire.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of 2, ≥2)
- STARVE_MAX, 4, cycles a FIFO head may wait before stall_o asserts

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- pipe_wen_i  in  1  MEM/WB write request; never back-pressured
- pipe_waddr_i  in  5  MEM/WB destination register
- pipe_wdata_i  in  32  MEM/WB write data
- lu_valid_i  in  1  long-latency result valid
- lu_ready_o  out  1  FIFO can accept
- lu_waddr_i  in  5  long-latency destination register
- lu_wdata_i  in  32  long-latency result
- issue_i  in  1  ID issued a long-latency op this cycle
- issue_addr_i  in  5  its destination register
- rs1_addr_i  in  5  ID source 1 query
- rs2_addr_i  in  5  ID source 2 query
- rd_addr_i  in  5  ID destination query
- rs1_busy_o  out  1  rs1 pending in scoreboard
- rs2_busy_o  out  1  rs2 pending
- rd_busy_o  out  1  rd pending (WAW)
- stall_o  out  1  request pipeline bubble at WB
- wen_o  out  1  to regfile wen
- wr_addr_o  out  5  to regfile wr_addr_i
- wr_data_o  out  32  to regfile wr_data_i

Behaviour:

Clock and reset
- One clock, clk.
- rstn is asynchronous and active-low. While low, these are cleared: FIFO pointers and count, busy[31:1], and the age counter.
- Outputs during reset:
  - lu_ready_o=0
  - stall_o=0
  - wen_o=0, wr_addr_o=0, wr_data_o=0
  - all busy outputs 0
- Reset mid-operation discards buffered results. Upstream units are reset by the same rstn.

FIFO
- Push when lu_valid_i && lu_ready_o.
- lu_ready_o = (count != DEPTH). This is combinational from registered count, with no dependency on lu_valid_i.
- A push into a full FIFO cannot occur. A simultaneous pop in the same cycle does not raise ready in that cycle.
- Pointers wrap modulo DEPTH. count is DEPTH-sized plus 1 bit.
- A pushed entry is never written in its push cycle. Minimum push-to-write latency is 1 cycle.

Write port mux (combinational, zero latency)
- Case P, when pipe_wen_i && pipe_waddr_i != 0: drive the pipe address and data, wen_o=1. The FIFO does not pop.
- Otherwise, when count != 0: drive the FIFO head, wen_o=1, pop this cycle.
- Otherwise: wen_o=0, wr_addr_o=0, wr_data_o=0.
- A pipe write to x0 counts as idle, so the FIFO may drain that cycle.
- A FIFO entry with address 0 pops with wen_o=0. It clears nothing.

Scoreboard (busy[31:1])
- Set: issue_i && issue_addr_i != 0 sets busy[issue_addr_i] at the next edge.
- Clear: a FIFO pop clears busy[head addr] at the next edge.
- Set and clear of the same address in one cycle: set wins.
- Busy outputs are combinational reads of registered busy. Address 0 always reads 0.
- Result-to-ID timing: no bypass. A result is visible to ID one cycle after its regfile write, with busy clear in the same edge.
- Issue to an already busy rd is illegal, because ID must stall on rd_busy_o. The bench flags this with an assertion.

Starvation
- age increments each cycle in which count != 0 and case P holds.
- age resets to 0 on any pop or when count == 0.
- age saturates at STARVE_MAX.
- stall_o = (age == STARVE_MAX), registered.
- While stall_o=1 the pipeline presents pipe_wen_i=0 (bubble). The head then pops, which clears age and drops stall_o on the next edge.

Test Plan:
1. Pipe-only traffic: pipe write x5=0x1234 → same-cycle wen_o=1, wr_addr_o=5, wr_data_o=0x1234; FIFO untouched; busy all 0.
2. Long-latency path: issue x7 → rs1_busy_o=1 for rs1_addr_i=7 from the next cycle. Push x7=0xDEAD while the pipe is idle → written exactly 1 cycle later, then busy[7]=0.
3. Contention and full FIFO:
   - Pipe writes every cycle while two LU results are pushed → lu_ready_o=0 with count=2.
   - After 4 blocked cycles stall_o=1.
   - On the next pipe bubble the head pops in FIFO order, then the second pops the following cycle.
4. Edge cases:
   - Simultaneous issue of x9 and pop of an x9 entry → busy[9] stays 1.
   - Pipe write to x0 while the FIFO is non-empty → the FIFO head is written.
5. Reset mid-operation: assert rstn low asynchronously with count=2, busy[3]=1 → all outputs 0 immediately. After release, lu_ready_o=1 and no stale write appears.
6. Wrap-around: 10 back-to-back push/pop pairs with DEPTH=2 → data and addresses retire in order, with no loss or duplication.
